// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the CPU memory/IO responder.
// Access classes returned by decode() drive the responder datapath.
package mem_io_responder_pkg;

  localparam int          BYTE_W    = 8;
  localparam logic [17:0] IO_BASE   = 18'h30000;
  localparam logic [1:0]  IO_SEL    = IO_BASE[17:16];
  localparam logic [15:0] PORT_DATA = 16'h0000;
  localparam logic [15:0] PORT_CLK  = 16'h0004;

  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_RX,
    ACC_TX,
    ACC_CLK,
    ACC_STOP,
    ACC_NONE
  } acc_e;

  function automatic acc_e decode(
    input logic [17:0] a,
    input logic        wr
  );
    acc_e r;
    r = ACC_NONE;
    if (a[17:16] != IO_SEL) begin
      r = ACC_RAM;
    end else if (a[15:0] == PORT_DATA) begin
      r = wr ? ACC_TX : ACC_RX;
    end else if (a[15:2] == PORT_CLK[15:2]) begin
      if (!wr) begin
        r = ACC_CLK;
      end else if (a[1:0] == 2'b00) begin
        r = ACC_STOP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO, power-of-2 DEPTH, pointers one bit wider than the index.
// Ports: push/data in, pop, full/empty flags, combinational head byte.
import mem_io_responder_pkg::*;

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [BYTE_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              pop_ok;
  logic              push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot the push lands in, so full+pop may push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU bus responder: byte RAM, rx/tx byte FIFOs, cycle counter, stop flag.
// Ports: CPU bus (a/dout/wr in, din/rdy out), rx and tx byte streams.
import mem_io_responder_pkg::*;

module mem_io_responder #(
  parameter int ADDR_W   = 17,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       mem_a_i,
  input  logic [BYTE_W-1:0] mem_dout_i,
  input  logic              mem_wr_i,
  output logic [BYTE_W-1:0] mem_din_o,
  output logic              cpu_rdy_o,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              rx_ready_o,
  output logic              tx_valid_o,
  output logic [BYTE_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  output logic              prog_stop_o
);

  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic [17:0]       a;
  logic [ADDR_W-1:0] idx;
  acc_e              acc;
  logic              rd;
  logic              unused_a;

  assign a        = mem_a_i[17:0];
  assign idx      = mem_a_i[ADDR_W-1:0];
  assign rd       = !mem_wr_i;
  assign acc      = decode(a, mem_wr_i);
  assign unused_a = ^mem_a_i[31:18];

  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic [BYTE_W-1:0] rx_head, tx_head, tx_wdata;
  logic              tx_want, stall, acc_ok;

  assign tx_want = (acc == ACC_STOP) ||
                   (acc == ACC_TX && mem_dout_i != '0);
  assign tx_pop  = !tx_empty && tx_ready_i;
  assign rx_push = rx_valid_i && !rx_full;

  // A host pop in the same cycle frees the slot the CPU write needs.
  assign stall = (acc == ACC_RX && rx_empty) ||
                 (tx_want && tx_full && !tx_pop);

  // Reset wins over any stall so the CPU is released immediately.
  assign cpu_rdy_o = !(stall && rst_in);
  assign acc_ok    = rst_in && !stall;

  assign rx_pop   = acc_ok && acc == ACC_RX;
  assign tx_push  = acc_ok && tx_want;
  assign tx_wdata = (acc == ACC_STOP) ? '0 : mem_dout_i;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .push_i (rx_push),
    .data_i (rx_data_i),
    .pop_i  (rx_pop),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .head_o (rx_head)
  );

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .push_i (tx_push),
    .data_i (tx_wdata),
    .pop_i  (tx_pop),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .head_o (tx_head)
  );

  assign rx_ready_o = !rx_full;
  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_head;

  logic [BYTE_W-1:0] ram_q [RAM_DEPTH];
  logic [BYTE_W-1:0] ram_rd_q;
  logic              ram_we, ram_re;

  assign ram_we = acc_ok && acc == ACC_RAM && mem_wr_i;
  assign ram_re = acc_ok && acc == ACC_RAM && rd;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[idx] <= mem_dout_i;
    if (ram_re) ram_rd_q <= ram_q[idx];
  end

  logic [31:0]       counter_q, counter_d;
  logic [31:0]       snap_q, snap_d;
  logic [BYTE_W-1:0] io_q, io_d;
  logic [BYTE_W-1:0] clk_byte;
  logic              sel_ram_q, sel_ram_d;
  logic              stop_q, stop_d;

  // Offset 4 reads the live low byte; 5..7 read the captured snapshot.
  always_comb begin
    unique case (a[1:0])
      2'd0:    clk_byte = counter_q[7:0];
      2'd1:    clk_byte = snap_q[15:8];
      2'd2:    clk_byte = snap_q[23:16];
      default: clk_byte = snap_q[31:24];
    endcase
  end

  always_comb begin
    counter_d = counter_q + 32'd1;
    snap_d    = snap_q;
    io_d      = io_q;
    sel_ram_d = sel_ram_q;
    stop_d    = stop_q;
    if (acc_ok) begin
      unique case (1'b1)
        rd && acc == ACC_RAM: sel_ram_d = 1'b1;
        acc == ACC_RX: begin
          io_d      = rx_head;
          sel_ram_d = 1'b0;
        end
        acc == ACC_CLK: begin
          io_d      = clk_byte;
          sel_ram_d = 1'b0;
          if (a[1:0] == 2'b00) snap_d = counter_q;
        end
        acc == ACC_STOP: stop_d = 1'b1;
        rd && acc == ACC_NONE: begin
          io_d      = '0;
          sel_ram_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      counter_q <= '0;
      snap_q    <= '0;
      io_q      <= '0;
      sel_ram_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      snap_q    <= snap_d;
      io_q      <= io_d;
      sel_ram_q <= sel_ram_d;
      stop_q    <= stop_d;
    end
  end

  assign mem_din_o   = sel_ram_q ? ram_rd_q : io_q;
  assign prog_stop_o = stop_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM vectors, rx/tx FIFOs,
// cycle counter snapshot, program stop and reset during a stall.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din_o;
  logic        cpu_rdy_o;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready;
  logic        prog_stop_o;

  always #5 clk = ~clk;

  mem_io_responder dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .mem_a_i    (mem_a),
    .mem_dout_i (mem_dout),
    .mem_wr_i   (mem_wr),
    .mem_din_o  (mem_din_o),
    .cpu_rdy_o  (cpu_rdy_o),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready),
    .prog_stop_o(prog_stop_o)
  );

  int         checks = 0;
  int         failures = 0;
  int         tx_pops = 0;
  logic [7:0] rdq[$];
  logic [7:0] txq[$];
  logic [7:0] last_rd;
  logic [31:0] m_cnt;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 32'd0;
    else m_cnt <= m_cnt + 32'd1;
  end

  always @(negedge clk) begin
    if (rst_n && tx_valid_o && tx_ready) begin
      tx_pops++;
      if (txq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra: got %0h expected none", tx_data_o);
      end else begin
        chk("tx_data", 32'(tx_data_o), 32'(txq.pop_front()));
      end
    end
  end

  task automatic set_idle();
    mem_a    = 32'h0003_0008;
    mem_wr   = 1'b1;
    mem_dout = 8'h00;
  endtask

  task automatic check_rd(string name);
    logic [7:0] e;
    if (rdq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0h expected nothing queued", name, mem_din_o);
    end else begin
      e = rdq.pop_front();
      chk(name, 32'(mem_din_o), 32'(e));
      last_rd = e;
    end
  endtask

  // Entered and left at posedge+1; one access then one idle cycle.
  task automatic bus(string name, logic [31:0] a, logic wr,
                     logic [7:0] d, logic [7:0] exp);
    int n;
    n = 0;
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    if (!wr) rdq.push_back(exp);
    @(negedge clk);
    while (!cpu_rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_rdy_o) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: rdy=0 expected 1", name);
      rdq.delete();
      set_idle();
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    if (!wr) check_rd(name);
    else chk({name, "_hold"}, 32'(mem_din_o), 32'(last_rd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int p0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    last_rd  = 8'h00;
    set_idle();

    tbl[0]  = '{32'h0000_0100, 1'b1, 8'hA5, 8'h00};
    tbl[1]  = '{32'h0000_0100, 1'b0, 8'h00, 8'hA5};
    tbl[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 8'h00};
    tbl[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h3C};
    tbl[4]  = '{32'h0000_0000, 1'b1, 8'h5A, 8'h00};
    tbl[5]  = '{32'h0000_0100, 1'b0, 8'h00, 8'hA5};
    tbl[6]  = '{32'h0000_0000, 1'b0, 8'h00, 8'h5A};
    tbl[7]  = '{32'h0003_0010, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h3C};
    tbl[9]  = '{32'h0002_0100, 1'b0, 8'h00, 8'hA5};
    tbl[10] = '{32'h0003_0003, 1'b0, 8'h00, 8'h00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_din", 32'(mem_din_o), 32'h0);
    chk("rst_rdy", 32'(cpu_rdy_o), 32'h1);
    chk("rst_txv", 32'(tx_valid_o), 32'h0);
    chk("rst_rxr", 32'(rx_ready_o), 32'h1);
    chk("rst_stop", 32'(prog_stop_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      bus($sformatf("vec%0d", i), tbl[i].a, tbl[i].wr, tbl[i].d, tbl[i].exp);

    n = 0;
    while (m_cnt != 32'h1F4 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_cnt != 32'h1F4) begin
      checks++;
      failures++;
      $display("FAIL cnt_align: got %0h expected 1f4", m_cnt);
    end
    bus("clk0", 32'h0003_0004, 1'b0, 8'h00, 8'hF4);
    bus("clk1", 32'h0003_0005, 1'b0, 8'h00, 8'h01);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    bus("clk2", 32'h0003_0006, 1'b0, 8'h00, 8'h00);
    bus("clk3", 32'h0003_0007, 1'b0, 8'h00, 8'h00);
    bus("clk1b", 32'h0003_0005, 1'b0, 8'h00, 8'h01);

    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(posedge clk);
    #1;
    rx_data = 8'h42;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    bus("rx0", 32'h0003_0000, 1'b0, 8'h00, 8'h41);
    bus("rx1", 32'h0003_0000, 1'b0, 8'h00, 8'h42);
    mem_a  = 32'h0003_0000;
    mem_wr = 1'b0;
    rdq.push_back(8'h43);
    repeat (3) begin
      @(negedge clk);
      chk("rx_stall", 32'(cpu_rdy_o), 32'h0);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h43;
    @(negedge clk);
    chk("rx_stall_push", 32'(cpu_rdy_o), 32'h0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rx_go", 32'(cpu_rdy_o), 32'h1);
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    check_rd("rx2");
    @(posedge clk);
    #1;

    tx_ready = 1'b1;
    txq.push_back(8'h48);
    txq.push_back(8'h49);
    bus("tx0", 32'h0003_0000, 1'b1, 8'h48, 8'h00);
    bus("tx1", 32'h0003_0000, 1'b1, 8'h00, 8'h00);
    bus("tx2", 32'h0003_0000, 1'b1, 8'h49, 8'h00);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("tx_drain", 32'(txq.size()), 32'h0);
    chk("tx_count", 32'(tx_pops), 32'd2);

    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      txq.push_back(8'(i));
      bus("txf", 32'h0003_0000, 1'b1, 8'(i), 8'h00);
    end
    chk("tx_full_valid", 32'(tx_valid_o), 32'h1);
    p0 = tx_pops;
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b1;
    mem_dout = 8'h11;
    txq.push_back(8'h11);
    repeat (2) begin
      @(negedge clk);
      chk("tx_full_stall", 32'(cpu_rdy_o), 32'h0);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_full_go", 32'(cpu_rdy_o), 32'h1);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    set_idle();
    @(negedge clk);
    chk("tx_full_one_pop", 32'(tx_pops - p0), 32'd1);
    chk("tx_full_still", 32'(tx_valid_o), 32'h1);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("tx_full_drain", 32'(txq.size()), 32'h0);

    chk("stop_pre", 32'(prog_stop_o), 32'h0);
    txq.push_back(8'h00);
    bus("stop", 32'h0003_0004, 1'b1, 8'h77, 8'h00);
    bus("io_ign", 32'h0003_0005, 1'b1, 8'h55, 8'h00);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("stop_set", 32'(prog_stop_o), 32'h1);
    chk("stop_tx0", 32'(txq.size()), 32'h0);

    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h60 + i);
      @(posedge clk);
      #1;
    end
    rx_data = 8'h70;
    mem_a   = 32'h0003_0000;
    mem_wr  = 1'b0;
    rdq.push_back(8'h60);
    @(negedge clk);
    chk("rx_full_ready", 32'(rx_ready_o), 32'h0);
    chk("rx_full_rdy", 32'(cpu_rdy_o), 32'h1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    set_idle();
    @(negedge clk);
    check_rd("rxf0");
    @(posedge clk);
    #1;
    for (int i = 1; i < 16; i++)
      bus("rxf", 32'h0003_0000, 1'b0, 8'h00, 8'(8'h60 + i));
    mem_a  = 32'h0003_0000;
    mem_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rx_no_push", 32'(cpu_rdy_o), 32'h0);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 32'(cpu_rdy_o), 32'h1);
    chk("mrst_rxr", 32'(rx_ready_o), 32'h1);
    chk("mrst_txv", 32'(tx_valid_o), 32'h0);
    chk("mrst_stop", 32'(prog_stop_o), 32'h0);
    chk("mrst_din", 32'(mem_din_o), 32'h0);
    rdq.delete();
    txq.delete();
    last_rd = 8'h00;
    set_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus("cnt_rst", 32'h0003_0004, 1'b0, 8'h00, 8'h00);
    bus("snap_rst", 32'h0003_0006, 1'b0, 8'h00, 8'h00);
    bus("ram_keep0", 32'h0000_0100, 1'b0, 8'h00, 8'hA5);
    bus("ram_keep1", 32'h0001_FFFF, 1'b0, 8'h00, 8'h3C);
    bus("ram_keep2", 32'h0000_0000, 1'b0, 8'h00, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
